// File: rtl/layer_feeder.sv
// Generates pseudo-random 7-column layer maps and sequences load/start strobes
// for the scrolling layer chain: initial fill after reset, then one layer per scroll.
module layer_feeder #(
    parameter int          NUM_LAYERS   = 5,
    parameter int          SCROLL_TICKS = 150,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        module_en,
    input  logic        one_ms_tick,
    input  logic        scroll_req,
    output logic        load,
    output logic        start,
    output logic [6:0]  layer_map,
    output logic [6:0]  block_type,
    output logic [6:0]  bonus_map,
    output logic        busy,
    output logic [15:0] layers_generated
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int TW = $clog2(SCROLL_TICKS + 2);
    localparam logic [IW-1:0] LAST_ITER = IW'(NUM_LAYERS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(SCROLL_TICKS);

    typedef enum logic [2:0] {
        S_INIT,
        S_LOAD,
        S_IDLE,
        S_GEN,
        S_START,
        S_SCROLL,
        S_DONE
    } state_t;

    state_t          state, next_state;
    logic [15:0]     lfsr, lfsr_next;
    logic [IW-1:0]   init_cnt;
    logic [TW-1:0]   tick_cnt;
    logic [2:0]      pos;
    logic [6:0]      cand, gen_bt, gen_bonus;
    logic            gen_en, ground, count_gen;
    logic            init_inc, init_clr, tick_clr, tick_inc;

    assign lfsr_next = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400)
                               : {1'b0, lfsr[15:1]};

    // An all-empty row is never emitted: one column is forced on instead.
    always_comb begin
        pos       = (lfsr[9:7] == 3'd7) ? 3'd3 : lfsr[9:7];
        cand      = (lfsr[6:0] == 7'd0) ? (7'd1 << pos) : lfsr[6:0];
        gen_bt    = lfsr[13:7] & cand;
        gen_bonus = (lfsr[15:14] == 2'b11) ? (cand & (~cand + 7'd1)) : 7'd0;
    end

    always_comb begin
        next_state = state;
        gen_en     = 1'b0;
        ground     = 1'b0;
        count_gen  = 1'b0;
        init_inc   = 1'b0;
        init_clr   = 1'b0;
        tick_clr   = 1'b0;
        tick_inc   = 1'b0;
        if (module_en) begin
            unique case (state)
                S_INIT: begin
                    gen_en     = 1'b1;
                    ground     = (init_cnt == '0);
                    next_state = S_LOAD;
                end
                S_LOAD: begin
                    if (init_cnt == LAST_ITER) begin
                        init_clr   = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        init_inc   = 1'b1;
                        next_state = S_INIT;
                    end
                end
                S_IDLE: begin
                    if (scroll_req) next_state = S_GEN;
                end
                S_GEN: begin
                    gen_en     = 1'b1;
                    count_gen  = 1'b1;
                    next_state = S_START;
                end
                S_START: begin
                    tick_clr   = 1'b1;
                    next_state = S_SCROLL;
                end
                S_SCROLL: begin
                    if (one_ms_tick) begin
                        tick_inc = 1'b1;
                        if (tick_cnt == LAST_TICK) next_state = S_DONE;
                    end
                end
                S_DONE: next_state = S_IDLE;
                default: next_state = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
            lfsr  <= SEED_EFF;
            load  <= 1'b0;
            start <= 1'b0;
            busy  <= 1'b1;
        end else if (module_en) begin
            state <= next_state;
            lfsr  <= lfsr_next;
            load  <= (next_state == S_LOAD);
            start <= (next_state == S_START);
            busy  <= (next_state != S_IDLE);
        end else begin
            // A pulse interrupted by a freeze is dropped, never replayed.
            load  <= 1'b0;
            start <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_map        <= 7'd0;
            block_type       <= 7'd0;
            bonus_map        <= 7'd0;
            layers_generated <= 16'd0;
            init_cnt         <= '0;
            tick_cnt         <= '0;
        end else begin
            if (gen_en) begin
                layer_map  <= ground ? 7'h7F : cand;
                block_type <= ground ? 7'd0  : gen_bt;
                bonus_map  <= ground ? 7'd0  : gen_bonus;
            end
            if (count_gen && layers_generated != 16'hFFFF)
                layers_generated <= layers_generated + 16'd1;
            if (init_clr)
                init_cnt <= '0;
            else if (init_inc)
                init_cnt <= init_cnt + 1'b1;
            if (tick_clr)
                tick_cnt <= '0;
            else if (tick_inc)
                tick_cnt <= tick_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_layer_feeder.sv
// Randomized self-checking bench for layer_feeder against a
// behavioural model of the LFSR, map generation and scroll timing.
module tb_layer_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        module_en = 1'b1;
    logic        one_ms_tick = 1'b0;
    logic        scroll_req = 1'b0;
    logic        load, start, busy;
    logic [6:0]  layer_map, block_type, bonus_map;
    logic [15:0] layers_generated;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    int          m_lg = 0;

    layer_feeder dut (
        .clk              (clk),
        .rst              (rst),
        .module_en        (module_en),
        .one_ms_tick      (one_ms_tick),
        .scroll_req       (scroll_req),
        .load             (load),
        .start            (start),
        .layer_map        (layer_map),
        .block_type       (block_type),
        .bonus_map        (bonus_map),
        .busy             (busy),
        .layers_generated (layers_generated)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // {layer_map, block_type, bonus_map} for a GEN cycle seeing lfsr value v
    function automatic logic [20:0] gen_ref(input logic [15:0] v);
        logic [6:0] c, bt, bn;
        int p;
        bit found;
        c = v[6:0];
        if (c == 7'd0) begin
            p = int'(v[9:7]);
            if (p == 7) p = 3;
            c[p] = 1'b1;
        end
        bt = 7'd0;
        bn = 7'd0;
        found = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bt[i] = v[7+i] & c[i];
            if (v[15] && v[14] && c[i] && !found) begin
                bn[i] = 1'b1;
                found = 1'b1;
            end
        end
        return {c, bt, bn};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)
            m_lfsr <= 16'hACE1;
        else if (module_en)
            m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] maps();
        return 32'({layer_map, block_type, bonus_map});
    endfunction

    // Call right after rst drops at a falling edge.
    task automatic do_init();
        logic [15:0] rec;
        rec = 16'h0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check_eq($sformatf("init_load%0d", k), 32'(load), k % 2);
            check_eq($sformatf("init_busy%0d", k), 32'(busy), 32'(k < 10));
            check_eq($sformatf("init_start%0d", k), 32'(start), 0);
            if (k == 1)
                check_eq("init_ground", maps(), 32'({7'h7F, 14'h0}));
            else if (k % 2 == 1)
                check_eq($sformatf("init_map%0d", k), maps(), 32'(gen_ref(rec)));
            else
                rec = m_lfsr;
        end
        check_eq("init_lg", 32'(layers_generated), 32'(m_lg));
    endtask

    task automatic run_scroll(input bit tick_with_req, input int freeze_at,
                              input bit want_pattern, input int abort_at);
        logic [15:0] rec, nx;
        logic [31:0] exp;
        int w;
        if (want_pattern) begin
            w = 0;
            nx = lfsr_step(m_lfsr);
            while (!(nx[6:0] == 7'd0 && nx[9:7] == 3'b111) && w < 70000) begin
                @(negedge clk);
                w++;
                nx = lfsr_step(m_lfsr);
            end
            check_eq("pattern_wait", 32'(w < 70000), 1);
        end
        check_eq("idle_busy", 32'(busy), 0);
        scroll_req = 1'b1;
        one_ms_tick = tick_with_req;
        @(negedge clk);
        scroll_req = 1'b0;
        one_ms_tick = 1'b0;
        check_eq("gen_busy", 32'(busy), 1);
        check_eq("gen_start", 32'(start), 0);
        rec = m_lfsr;
        if (m_lg < 65535) m_lg++;
        @(negedge clk);
        exp = 32'(gen_ref(rec));
        check_eq("start_pulse", 32'(start), 1);
        check_eq("start_maps", maps(), exp);
        check_eq("start_lg", 32'(layers_generated), 32'(m_lg));
        if (want_pattern) begin
            check_eq("pat_map", 32'(layer_map), 32'(7'b0001000));
            check_eq("pat_bt_subset", 32'(block_type & ~layer_map), 0);
            check_eq("pat_bonus_1hot", 32'($countones(bonus_map) <= 1), 1);
        end
        one_ms_tick = 1'b1;
        scroll_req = 1'b1;
        @(negedge clk);
        one_ms_tick = 1'b0;
        scroll_req = 1'b0;
        check_eq("start_once", 32'(start), 0);
        for (int t = 1; t <= 151; t++) begin
            repeat ($urandom_range(0, 3)) begin
                scroll_req = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
            scroll_req = 1'b0;
            if (t == freeze_at) begin
                module_en = 1'b0;
                repeat (500) begin
                    one_ms_tick = 1'($urandom_range(0, 1));
                    scroll_req = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    check_eq("freeze_outs", 32'({busy, start, load, maps()}),
                             32'({1'b1, 1'b0, 1'b0, exp}));
                end
                module_en = 1'b1;
                one_ms_tick = 1'b0;
                scroll_req = 1'b0;
            end
            if (t == abort_at) begin
                rst = 1'b1;
                #1;
                check_eq("abort_outs", 32'({load, start, maps()}), 0);
                check_eq("abort_busy", 32'(busy), 1);
                check_eq("abort_lg", 32'(layers_generated), 0);
                m_lg = 0;
                @(negedge clk);
                rst = 1'b0;
                do_init();
                return;
            end
            one_ms_tick = 1'b1;
            @(negedge clk);
            one_ms_tick = 1'b0;
            check_eq($sformatf("scroll_busy_t%0d", t), 32'(busy), 1);
            check_eq("scroll_start", 32'(start), 0);
            check_eq("scroll_maps", maps(), exp);
        end
        @(negedge clk);
        check_eq("done_busy", 32'(busy), 0);
        check_eq("done_maps", maps(), exp);
        check_eq("done_lg", 32'(layers_generated), 32'(m_lg));
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check_eq("rst_outs", 32'({load, start, maps()}), 0);
        check_eq("rst_busy", 32'(busy), 1);
        check_eq("rst_lg", 32'(layers_generated), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_init();
        run_scroll(1'b0, 0, 1'b0, 0);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        run_scroll(1'b1, 0, 1'b0, 0);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        run_scroll(1'b0, 40, 1'b0, 0);
        run_scroll(1'b0, 0, 1'b1, 0);
        run_scroll(1'b0, 0, 1'b0, 60);
        run_scroll(1'b0, 0, 1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
